// File: rtl/hu_scoreboard_stall_if.sv
// hu_scoreboard_stall_if: D-stage, writeback and hazard-control signals of the scoreboard
interface hu_scoreboard_stall_if;
  logic        valid_D;
  logic [4:0]  rs1_D;
  logic [4:0]  rs2_D;
  logic        rs1_used_D;
  logic        rs2_used_D;
  logic [4:0]  rd_D;
  logic        regwrite_D;
  logic        load_D;
  logic        muldiv_D;
  logic        redirect_E;
  logic        wb_valid_W;
  logic [4:0]  wb_rd_W;
  logic        md_done;
  logic        stall_F;
  logic        stall_D;
  logic        bubble_E;
  logic        flush_D;
  logic [31:0] pending;
  logic        md_busy;
  logic [15:0] stall_cnt;
  modport master (
    output valid_D, rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D, regwrite_D, load_D, muldiv_D,
    output redirect_E, wb_valid_W, wb_rd_W, md_done,
    input  stall_F, stall_D, bubble_E, flush_D, pending, md_busy, stall_cnt
  );
  modport slave (
    input  valid_D, rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D, regwrite_D, load_D, muldiv_D,
    input  redirect_E, wb_valid_W, wb_rd_W, md_done,
    output stall_F, stall_D, bubble_E, flush_D, pending, md_busy, stall_cnt
  );
endinterface

// File: rtl/hu_scoreboard_stall.sv
// hu_scoreboard_stall: long-latency result scoreboard with RAW/WAW/structural stall control
module hu_scoreboard_stall (
  input logic               clk,
  input logic               rst,
  hu_scoreboard_stall_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      r_state;
  logic [31:0] r_pending;
  logic [15:0] r_stall_cnt;
  logic        w_md_busy;
  logic        w_raw1;
  logic        w_raw2;
  logic        w_waw;
  logic        w_struct;
  logic        w_hazard;
  logic        w_stall;
  logic        w_issue;
  logic        w_md_issue;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  assign w_md_busy = (r_state == BUSY);
  // hazard detection; a writeback landing this cycle is forwarded, so it releases the stall
  always_comb begin
    w_raw1     = bus.valid_D & bus.rs1_used_D & (bus.rs1_D != 5'd0) & r_pending[bus.rs1_D]
                 & !(bus.wb_valid_W & (bus.wb_rd_W == bus.rs1_D));
    w_raw2     = bus.valid_D & bus.rs2_used_D & (bus.rs2_D != 5'd0) & r_pending[bus.rs2_D]
                 & !(bus.wb_valid_W & (bus.wb_rd_W == bus.rs2_D));
    w_waw      = bus.valid_D & bus.regwrite_D & (bus.rd_D != 5'd0) & r_pending[bus.rd_D]
                 & !(bus.wb_valid_W & (bus.wb_rd_W == bus.rd_D));
    w_struct   = bus.valid_D & bus.muldiv_D & w_md_busy & !bus.md_done;
    w_hazard   = w_raw1 | w_raw2 | w_waw | w_struct;
    w_stall    = w_hazard & !bus.redirect_E;
    w_issue    = bus.valid_D & !w_stall & !bus.redirect_E;
    w_md_issue = w_issue & bus.muldiv_D;
    w_set      = (w_issue & bus.regwrite_D & (bus.load_D | bus.muldiv_D) & (bus.rd_D != 5'd0))
                 ? (32'd1 << bus.rd_D) : 32'd0;
    w_clr      = (bus.wb_valid_W & (bus.wb_rd_W != 5'd0)) ? (32'd1 << bus.wb_rd_W) : 32'd0;
  end
  // scoreboard: set wins over a same-cycle clear so a fresh producer is never lost
  always_ff @(posedge clk) begin
    if (rst) r_pending <= 32'd0;
    else     r_pending <= (r_pending & ~w_clr) | w_set;
  end
  // mul/div occupancy; a back-to-back issue on the done cycle keeps the unit busy
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= (r_state == IDLE) ? (w_md_issue ? BUSY : IDLE)
                                          : ((bus.md_done & !w_md_issue) ? IDLE : BUSY);
  end
  // saturating count of stalled D cycles
  always_ff @(posedge clk) begin
    if (rst) r_stall_cnt <= 16'd0;
    else     r_stall_cnt <= r_stall_cnt + {15'd0, w_stall & (r_stall_cnt != 16'hFFFF)};
  end
  assign bus.stall_F   = w_stall;
  assign bus.stall_D   = w_stall;
  assign bus.bubble_E  = bus.redirect_E | w_hazard;
  assign bus.flush_D   = bus.redirect_E;
  assign bus.pending   = r_pending;
  assign bus.md_busy   = w_md_busy;
  assign bus.stall_cnt = r_stall_cnt;
endmodule
